mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port memory with fixed access latency.
// Optional MEM_ARBITER_RR_EN: break simultaneous requests by alternating instead of always favouring the data port.
module mem_arbiter #(
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_D  = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg;
  logic [DATA_W-1:0] addr_reg, wdata_reg;
  logic              we_reg;
  logic              if_ack_reg, d_ack_reg;
  logic [DATA_W-1:0] if_rdata_reg, d_rdata_reg;
  logic              if_elig, d_elig, done, start_if, start_d, prefer_d, grant;

  // A requester whose ack is showing this cycle is still presenting its old request.
  assign if_elig = if_req & ~if_ack_reg;
  assign d_elig  = d_req & ~d_ack_reg;
  assign done    = (state_reg != IDLE) && (cnt_reg == 4'd0);

`ifdef MEM_ARBITER_RR_EN
  logic last_grant_reg;  // 1 = data port was granted most recently

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b0;
    end else if (start_d) begin
      last_grant_reg <= 1'b1;
    end else if (start_if) begin
      last_grant_reg <= 1'b0;
    end
  end

  assign prefer_d = ~last_grant_reg;
`else
  assign prefer_d = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      we_reg       <= 1'b0;
      if_ack_reg   <= 1'b0;
      d_ack_reg    <= 1'b0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      if_ack_reg <= done && (state_reg == GRANT_IF);
      d_ack_reg  <= done && (state_reg == GRANT_D);
      if (done && (state_reg == GRANT_IF)) begin
        if_rdata_reg <= mem_rdata;
      end
      if (done && (state_reg == GRANT_D) && !we_reg) begin
        d_rdata_reg <= mem_rdata;
      end
      if (start_d) begin
        addr_reg  <= d_addr;
        we_reg    <= d_we;
        wdata_reg <= d_wdata;
        cnt_reg   <= LAT_M1;
      end else if (start_if) begin
        addr_reg  <= if_addr;
        we_reg    <= 1'b0;
        wdata_reg <= '0;
        cnt_reg   <= LAT_M1;
      end else if (cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end
  end

  // On completion only the other requester may follow, giving back-to-back grants.
  always_comb begin
    start_if   = 1'b0;
    start_d    = 1'b0;
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        start_d  = d_elig & (~if_elig | prefer_d);
        start_if = if_elig & ~start_d;
      end
      GRANT_IF: start_d  = done & d_elig;
      GRANT_D:  start_if = done & if_elig;
      default:  state_next = IDLE;
    endcase
    if (start_d) begin
      state_next = GRANT_D;
    end else if (start_if) begin
      state_next = GRANT_IF;
    end else if (done) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    grant     = (state_reg != IDLE);
    busy      = grant;
    mem_en    = grant;
    mem_we    = (state_reg == GRANT_D) & we_reg;
    mem_addr  = grant ? addr_reg : '0;
    mem_wdata = grant ? wdata_reg : '0;
  end

  assign if_ack    = if_ack_reg;
  assign d_ack     = d_ack_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign stall_if  = if_req & ~if_ack_reg;
  assign stall_mem = d_req & ~d_ack_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single transactions, hand-built conflict/reset sequences,
// then random two-port traffic against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int LAT = 2;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, rst;
  logic        if_req, if_ack, d_req, d_we, d_ack;
  logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic        stall_if, stall_mem, mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.DATA_W(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(int i);
    logic [7:0] lo;
    lo = 8'(i);
    return (i == 16) ? 16'h1234 : {8'hA5, lo};
  endfunction

  // Memory device (combinational read) and the bench's own copy of what it should hold.
  logic        mem_init;
  logic [15:0] dev_mem [256];
  logic [15:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      dev_mem[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = dev_mem[mem_addr[7:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    bit          drop;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  // One transaction from idle; inputs are scrambled during the grant to show they are ignored.
  task automatic run_single(input vec_t v, input int idx);
    @(posedge clk); #1;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    @(negedge clk);
    chk("single_idle_busy", busy, 0);
    chk("single_stall", v.is_d ? stall_mem : stall_if, 1);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        if_addr = ~v.addr; d_addr = ~v.addr; d_wdata = ~v.wdata; d_we = ~v.we;
        if (v.drop) begin if_req = 1'b0; d_req = 1'b0; end
      end
      @(negedge clk);
      chk("single_mem_en", mem_en, 1);
      chk("single_mem_addr", mem_addr, v.addr);
      chk("single_mem_we", mem_we, v.is_d & v.we);
      if (v.is_d) chk("single_mem_wdata", mem_wdata, v.wdata);
      chk("single_no_ack", {if_ack, d_ack}, 0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_ack", {if_ack, d_ack}, v.is_d ? 2'b01 : 2'b10);
    chk("single_rdata", v.is_d ? d_rdata : if_rdata, v.exp_rdata);
    chk("single_ack_mem_en", mem_en, 0);
    if (v.is_d && v.we) ref_mem[v.addr[7:0]] = v.wdata;
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("single_after", {busy, if_ack, d_ack}, 0);
    chk("single_rdata_hold", v.is_d ? d_rdata : if_rdata, v.exp_rdata);
    $display("vec %0d: %s we=%0d addr=%h rdata=%h", idx, v.is_d ? "D" : "F", v.we, v.addr,
             v.is_d ? d_rdata : if_rdata);
  endtask

  // Both ports request read at cycle 0; first_d says which one must win.
  task automatic conflict(input logic [15:0] ia, input logic [15:0] da, input bit first_d,
                          input logic [15:0] exp_if, input logic [15:0] exp_d);
    logic [15:0] a1, a2;
    a1 = first_d ? da : ia;
    a2 = first_d ? ia : da;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = ia; d_req = 1'b1; d_we = 1'b0; d_addr = da;
    @(negedge clk);
    chk("cf_stall_if0", stall_if, 1);
    chk("cf_stall_mem0", stall_mem, 1);
    chk("cf_mem_en0", mem_en, 0);
    for (int c = 1; c <= 2 * LAT + 1; c++) begin
      @(posedge clk); #1;
      if (c == LAT + 2) begin
        if (first_d) d_req = 1'b0; else if_req = 1'b0;
      end
      @(negedge clk);
      chk("cf_mem_en", mem_en, c <= 2 * LAT);
      if (c <= LAT) chk("cf_addr_first", mem_addr, a1);
      else if (c <= 2 * LAT) chk("cf_addr_second", mem_addr, a2);
      if (c == LAT + 1) chk("cf_ack_first", {if_ack, d_ack}, first_d ? 2'b01 : 2'b10);
      else if (c == 2 * LAT + 1) chk("cf_ack_second", {if_ack, d_ack}, first_d ? 2'b10 : 2'b01);
      else chk("cf_no_ack", {if_ack, d_ack}, 0);
      chk("cf_stall_if", stall_if, first_d ? (c <= 2 * LAT) : (c <= LAT));
      chk("cf_stall_mem", stall_mem, first_d ? (c <= LAT) : (c <= 2 * LAT));
    end
    chk("cf_if_rdata", if_rdata, exp_if);
    chk("cf_d_rdata", d_rdata, exp_d);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("cf_idle", busy, 0);
    $display("conflict: first=%s if_rdata=%h d_rdata=%h", first_d ? "D" : "F", if_rdata, d_rdata);
  endtask

  // Reference model: owner (0 none, 1 fetch, 2 data) and cycles left in its grant.
  int          m_owner, m_left;
  logic [15:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  bit          m_we, m_if_ack, m_d_ack, m_last_d;

  task automatic model_step();
    bit fin, n_if_ack, n_d_ack, e_if, e_d;
    int pick;
    fin = (m_owner != 0) && (m_left == 1);
    n_if_ack = 1'b0;
    n_d_ack = 1'b0;
    if (fin && m_owner == 1) begin
      m_if_rdata = ref_mem[m_addr[7:0]];
      n_if_ack = 1'b1;
    end else if (fin) begin
      if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
      else m_d_rdata = ref_mem[m_addr[7:0]];
      n_d_ack = 1'b1;
    end
    if (m_owner != 0 && !fin) begin
      m_left--;
    end else begin
      e_if = if_req && !m_if_ack && !(fin && m_owner == 1);
      e_d  = d_req && !m_d_ack && !(fin && m_owner == 2);
      pick = 0;
      if (e_if && e_d) pick = (RR && !m_last_d) ? 2 : (RR ? 1 : 2);
      else if (e_d) pick = 2;
      else if (e_if) pick = 1;
      m_owner = pick;
      m_left = LAT;
      if (pick == 1) begin
        m_addr = if_addr; m_we = 1'b0; m_wdata = 16'h0; m_last_d = 1'b0;
      end else if (pick == 2) begin
        m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_last_d = 1'b1;
      end
    end
    m_if_ack = n_if_ack;
    m_d_ack = n_d_ack;
  endtask

  initial begin
    bit if_pend, d_pend;
    vec_t lone;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    vecs[0] = '{0, 0, 0, 16'h0010, 16'h0000, 16'h1234};
    vecs[1] = '{1, 0, 0, 16'h0040, 16'h0000, 16'hA540};
    vecs[2] = '{1, 1, 0, 16'h0040, 16'hBEEF, 16'hA540};
    vecs[3] = '{1, 0, 1, 16'h0040, 16'h0000, 16'hBEEF};
    vecs[4] = '{0, 0, 0, 16'h0040, 16'h0000, 16'hBEEF};
    vecs[5] = '{0, 0, 0, 16'h00FF, 16'h0000, 16'hA5FF};
    vecs[6] = '{1, 1, 0, 16'h0003, 16'h0F0F, 16'hBEEF};
    vecs[7] = '{0, 0, 1, 16'h0003, 16'h0000, 16'h0F0F};

    // Reset with both requests up.
    rst = 1'b1; mem_init = 1'b1;
    if_req = 1'b1; if_addr = 16'h0011; d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0022; d_wdata = 16'h3333;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      mem_init = 1'b0;
      @(negedge clk);
      chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
      chk("rst_ports", {if_ack, d_ack, busy, if_rdata, d_rdata}, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("rst_release_idle", {busy, mem_en}, 0);

    for (int i = 0; i < 8; i++) run_single(vecs[i], i);

    conflict(16'h0020, 16'h0030, 1'b1, 16'hA520, 16'hA530);

    lone = '{1, 0, 0, 16'h0050, 16'h0000, 16'hA550};
    run_single(lone, 8);
    repeat (3) @(posedge clk);
    conflict(16'h0060, 16'h0070, !RR, 16'hA560, 16'hA570);

    // Reset in the first grant cycle aborts the fetch.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0077;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    chk("abort_grant", mem_en, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_en", mem_en, 0);
    chk("abort_state", {busy, if_ack, d_ack, if_rdata, d_rdata}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_no_ack", {if_ack, d_ack, busy}, 0);
    $display("reset mid-grant: mem_en=%0d if_ack=%0d", mem_en, if_ack);

    // Random two-port traffic; the model starts from the post-reset idle state.
    m_owner = 0; m_left = 0; m_addr = 0; m_wdata = 0; m_we = 0;
    m_if_ack = 0; m_d_ack = 0; m_if_rdata = 0; m_d_rdata = 0; m_last_d = 0;
    if_pend = 0; d_pend = 0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      if (!if_pend) begin
        if ($urandom_range(2) == 0) begin
          if_pend = 1'b1; if_req = 1'b1; if_addr = 16'($urandom_range(255));
        end else begin
          if_req = 1'b0;
        end
      end
      if (!d_pend) begin
        if ($urandom_range(2) == 0) begin
          d_pend = 1'b1; d_req = 1'b1; d_addr = 16'($urandom_range(255));
          d_we = 1'($urandom_range(1)); d_wdata = 16'($urandom);
        end else begin
          d_req = 1'b0;
        end
      end
      @(negedge clk);
      chk("rnd_mem_en", mem_en, m_owner != 0);
      chk("rnd_busy", busy, m_owner != 0);
      chk("rnd_mem_addr", mem_addr, (m_owner != 0) ? m_addr : 16'h0);
      chk("rnd_mem_we", mem_we, (m_owner == 2) && m_we);
      if (m_owner != 1) chk("rnd_mem_wdata", mem_wdata, (m_owner == 2) ? m_wdata : 16'h0);
      chk("rnd_acks", {if_ack, d_ack}, {m_if_ack, m_d_ack});
      chk("rnd_if_rdata", if_rdata, m_if_rdata);
      chk("rnd_d_rdata", d_rdata, m_d_rdata);
      chk("rnd_stalls", {stall_if, stall_mem}, {if_req & ~m_if_ack, d_req & ~m_d_ack});
      if (m_if_ack) begin
        if_pend = 1'b0;
        $display("rnd t=%0d F ack rdata=%h", t, if_rdata);
      end
      if (m_d_ack) begin
        d_pend = 1'b0;
        $display("rnd t=%0d D ack rdata=%h", t, d_rdata);
      end
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
